nr_div_result_stage: RTL
========================

# nr_div_result_stage

Downstream stage of the 4-bit combinational non-restoring divider. It captures each divider result together with its operands and applies the final remainder-restoration step. It also handles divide-by-zero, then buffers results in a small FIFO and presents them on a valid/ready interface to the consumer. Every division result leaving the divider datapath passes through it.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 8: width of the delivered-result counter.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: divider result and operands are valid this cycle.
- in_ready, output, 1: stage can accept; equals !full.
- div_x, input, 4: dividend presented to the divider.
- div_y, input, 4: divisor presented to the divider.
- div_r, input, 5: raw final partial remainder, two's complement, not yet restored.
- div_q, input, 4: quotient from the divider.
- out_valid, output, 1: FIFO head valid.
- out_ready, input, 1: consumer accepts the head.
- out_quot, output, 4: quotient at the head.
- out_rem, output, 4: restored remainder at the head.
- out_dbz, output, 1: head entry was a divide-by-zero.
- result_count, output, CNT_W: number of results delivered.
- check_err, output, 1: sticky self-check failure; see Configuration.

## Operation
- **Accept:** a transfer happens when in_valid && in_ready. The entry is written at that clock edge. No input is accepted when the FIFO is full, even if a pop occurs in the same cycle.
- **Correction (combinational, before the FIFO write):**
  - If div_y == 0: quot = 4'hF, rem = div_x, dbz = 1. div_r and div_q are ignored.
  - Else if div_r[4] == 1: rem = (div_r + {1'b0, div_y})[3:0], quot = div_q, dbz = 0.
  - Else: rem = div_r[3:0], quot = div_q, dbz = 0.
- **FIFO:** DEPTH entries of 9 bits {dbz, rem, quot}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are resolved with an extra wrap bit or an occupancy counter.
- **Pop:** a pop happens when out_valid && out_ready. The outputs show the head entry directly, with no read latency.
- **Simultaneous push and pop:**
  - Non-empty FIFO: occupancy is unchanged, both pointers advance.
  - Empty FIFO: there is no pop (out_valid=0); the push lands and out_valid rises the next cycle.
- **Head stability:** while out_valid=1 and out_ready=0, out_quot, out_rem and out_dbz stay stable.
- **result_count:** increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- **Reset mid-operation:** all buffered entries are discarded. In-flight data is not preserved.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; out_valid=0; out_quot=0; out_rem=0; out_dbz=0; result_count=0; check_err=0; pointers and occupancy at 0.
- Latency: an accept at edge N makes out_valid=1 from cycle N+1 when the FIFO was empty.
- Throughput: one result per cycle in, one per cycle out.
- in_ready depends only on registered state. It has no combinational path from out_ready.
- out_valid and the out_* data are driven from registers or the FIFO array only.

## Configuration
- DIV_RESULT_CHECK_EN defined:
  - Every accepted non-dbz entry is checked: div_x == quot*div_y + rem, and rem < div_y, computed at 8-bit width.
  - A mismatch sets check_err at the accept edge. check_err stays set until rst.
  - dbz entries are exempt from the check.
- Not defined: check_err is tied to 0 and the checker logic is absent.

## Test plan
- **Clean divides, no backpressure** (out_ready=1): push (6,2,r=0,q=3), (12,3,r=0,q=4), (13,12,r=1,q=1). Required: outputs q/r = 3/0, 4/0, 1/1 in order, each one cycle after its accept; result_count=3.
- **Negative remainder restore:** push div_x=5, div_y=10, div_r=5'b11011, div_q=0. Required: out_rem=5, out_quot=0, out_dbz=0.
- **Divide-by-zero:** push div_x=9, div_y=0, arbitrary div_r and div_q. Required: out_quot=F, out_rem=9, out_dbz=1, check_err stays 0.
- **Full/backpressure** (DEPTH=4): out_ready=0, push 5 results back-to-back. Required: in_ready drops after the 4th accept and the 5th is held off. Then out_ready=1 with in_valid high: pops come out in order, in_ready returns the cycle after the first pop, and no data is lost or duplicated.
- **Counter wrap and reset:**
  - Deliver 256 results: result_count wraps to 0.
  - Assert rst with 2 entries buffered: out_valid=0 next cycle and the buffered entries never appear.
- **With DIV_RESULT_CHECK_EN:** push div_x=14, div_y=9, div_r=5, div_q=2 (inconsistent). Required: check_err=1 after the accept edge and it stays set until rst.

Source files
------------

// File: rtl/nr_div_result_stage.sv
// Result stage behind the 4-bit non-restoring divider: restores the remainder, flags divide-by-zero,
// and buffers results in a DEPTH-entry FIFO. Optional self-check enabled by DIV_RESULT_CHECK_EN.
module nr_div_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       div_x,
  input  logic [3:0]       div_y,
  input  logic [4:0]       div_r,
  input  logic [3:0]       div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_quot,
  output logic [3:0]       out_rem,
  output logic             out_dbz,
  output logic [CNT_W-1:0] result_count,
  output logic             check_err
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic       dbz;
    logic [3:0] rem;
    logic [3:0] quot;
  } entry_t;

  entry_t             wr_ent;
  entry_t             head;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     occ;
  logic               full, push, pop;

  assign full      = (occ == (PTR_W+1)'(DEPTH));
  assign in_ready  = ~rst & ~full;
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Negative raw remainder is restored by adding the divisor back; mod-16 add keeps the low nibble.
  always_comb begin
    wr_ent = '0;
    if (div_y == 4'd0) begin
      wr_ent.dbz  = 1'b1;
      wr_ent.quot = 4'hF;
      wr_ent.rem  = div_x;
    end else begin
      wr_ent.quot = div_q;
      wr_ent.rem  = div_r[4] ? (div_r[3:0] + div_y) : div_r[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      result_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        result_count <= result_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  // Head is read straight from the array; outputs are forced to zero while empty.
  assign head     = mem[rd_ptr];
  assign out_quot = out_valid ? head.quot : 4'd0;
  assign out_rem  = out_valid ? head.rem  : 4'd0;
  assign out_dbz  = out_valid ? head.dbz  : 1'b0;

`ifdef DIV_RESULT_CHECK_EN
  logic [7:0] recon;
  assign recon = {4'd0, wr_ent.quot} * {4'd0, div_y} + {4'd0, wr_ent.rem};

  always_ff @(posedge clk) begin
    if (rst)
      check_err <= 1'b0;
    else if (push && !wr_ent.dbz && ((recon != {4'd0, div_x}) || (wr_ent.rem >= div_y)))
      check_err <= 1'b1;
  end
`else
  assign check_err = 1'b0;
`endif

endmodule
